// File: rtl/t01_preview_queue.sv
// Multi-slot "next pieces" preview: shadow queue committed at frame start,
// optional slide-up animation, 2-stage registered pixel colour.
// Ports: clk, rst (sync, active-high), x/y pixel position, frame_start pulse,
//        push_valid/push_data/push_ready queue advance, anim_busy, color_out.
module t01_preview_queue #(
    parameter int NUM_SLOTS  = 3,
    parameter int CELL_PX    = 20,
    parameter int SLOT_GAP   = 10,
    parameter int START_X    = 420,
    parameter int START_Y    = 100,
    parameter int BORDER_PX  = 2,
    parameter int ANIMATE    = 1,
    parameter int SLIDE_STEP = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_start,
    input  logic        push_valid,
    input  logic [47:0] push_data,
    output logic        push_ready,
    output logic        anim_busy,
    output logic [2:0]  color_out
);

    localparam int SLOT_PITCH = 4 * CELL_PX + SLOT_GAP;
    localparam int WIN_W      = 4 * CELL_PX;
    localparam int WIN_H      = NUM_SLOTS * SLOT_PITCH - SLOT_GAP;

    localparam logic [10:0] X0   = 11'(START_X);
    localparam logic [10:0] X1   = 11'(START_X + WIN_W);
    localparam logic [10:0] Y0   = 11'(START_Y);
    localparam logic [10:0] Y1   = 11'(START_Y + WIN_H);
    localparam logic [10:0] BX0  = 11'(START_X - BORDER_PX);
    localparam logic [10:0] BX1  = 11'(START_X + WIN_W + BORDER_PX);
    localparam logic [10:0] BY0  = 11'(START_Y - BORDER_PX);
    localparam logic [10:0] BY1  = 11'(START_Y + WIN_H + BORDER_PX);
    localparam logic [10:0] SPAN = 11'(NUM_SLOTS * SLOT_PITCH);

    localparam logic [9:0] PITCH10 = 10'(SLOT_PITCH);
    localparam logic [9:0] CELL10  = 10'(CELL_PX);
    localparam logic [9:0] WIN_W10 = 10'(WIN_W);
    localparam logic [9:0] STEP10  = 10'(SLIDE_STEP);
    localparam logic [9:0] START10 = (ANIMATE != 0) ? PITCH10 : 10'd0;

    // Number of whole steps contained in v, saturating at 3.
    function automatic logic [1:0] bucket(input logic [9:0] v,
                                          input logic [9:0] step);
        logic [1:0] b;
        b = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (v >= 10'(k) * step) b = 2'(k);
        end
        return b;
    endfunction

    // Slots beyond NUM_SLOTS stay zero; fixed depth keeps 2-bit indexing safe.
    logic [47:0] shadow [4];
    logic [47:0] disp   [4];
    logic        pending;
    logic [9:0]  anim_offset;

    assign push_ready = !pending;
    assign anim_busy  = (anim_offset != 10'd0);

    wire push_fire = push_valid && !pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
            pending     <= 1'b0;
            anim_offset <= '0;
        end else begin
            if (frame_start && pending) begin
                for (int i = 0; i < 4; i++) disp[i] <= shadow[i];
                pending     <= 1'b0;
                anim_offset <= START10;
            end else if (frame_start) begin
                anim_offset <= (anim_offset > STEP10) ?
                               anim_offset - STEP10 : 10'd0;
            end
            // push_fire implies pending=0, so it never collides with a commit.
            if (push_fire) begin
                for (int i = 0; i < 3; i++) begin
                    if (i < NUM_SLOTS - 1) shadow[i] <= shadow[i+1];
                end
                shadow[NUM_SLOTS-1] <= push_data;
                pending <= 1'b1;
            end
        end
    end

    // Stage 1: region classification and cell coordinates.
    logic [10:0] xe, ye;
    logic [9:0]  dy, ly, dx, w_c;
    logic [1:0]  slot_c;
    logic        in_win, in_brd, cell_c;

    always_comb begin
        xe     = {1'b0, x};
        ye     = {1'b0, y};
        in_win = (xe >= X0) && (xe < X1) && (ye >= Y0) && (ye < Y1);
        in_brd = (xe >= BX0) && (xe < BX1) && (ye >= BY0) && (ye < BY1)
                 && !in_win;
        // Only meaningful when in_win, which guards every use.
        dy     = 10'(ye - Y0);
        dx     = 10'(xe - X0);
        ly     = dy - anim_offset;
        slot_c = bucket(ly, PITCH10);
        w_c    = ly - 10'(slot_c) * PITCH10;
        cell_c = in_win && (dy >= anim_offset) && ({1'b0, ly} < SPAN)
                 && (w_c < WIN_W10);
    end

    logic       s1_border, s1_cell;
    logic [1:0] s1_slot, s1_col;
    logic [9:0] s1_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_border <= 1'b0;
            s1_cell   <= 1'b0;
            s1_slot   <= '0;
            s1_col    <= '0;
            s1_w      <= '0;
        end else begin
            s1_border <= in_brd;
            s1_cell   <= cell_c;
            s1_slot   <= slot_c;
            s1_col    <= bucket(dx, CELL10);
            s1_w      <= w_c;
        end
    end

    // Stage 2: cell lookup in the committed display slots.
    logic [1:0] row;
    logic [5:0] bit_ofs;

    always_comb begin
        row     = bucket(s1_w, CELL10);
        bit_ofs = 6'({row, s1_col}) * 6'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_out <= 3'b000;
        end else if (s1_border) begin
            color_out <= 3'b111;
        end else if (s1_cell) begin
            color_out <= disp[s1_slot][bit_ofs +: 3];
        end else begin
            color_out <= 3'b000;
        end
    end

endmodule
